// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per cycle, with sign fix-up.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] number1,
  input  logic [WIDTH-1:0] number2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [1:0]       op_q;
  logic             sign1, sign2;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    counter;

  logic             is_signed_c, neg1_c, neg2_c;
  logic [WIDTH-1:0] abs1_c, abs2_c;
  logic             div_zero_c, overflow_c, last_c, fits_c;
  logic [WIDTH:0]   rem_shift_c, rem_sub_c;
  logic [WIDTH-1:0] fix_c;

  // Operand decode and one restoring step
  always_comb begin
    is_signed_c = ~op[0];
    neg1_c      = is_signed_c & number1[WIDTH-1];
    neg2_c      = is_signed_c & number2[WIDTH-1];
    abs1_c      = neg1_c ? WIDTH'(-number1) : number1;
    abs2_c      = neg2_c ? WIDTH'(-number2) : number2;
    div_zero_c  = (number2 == '0);
    overflow_c  = is_signed_c && (number1 == MIN_NEG) && (number2 == '1);
    last_c      = (counter == CW'(WIDTH - 1));
    rem_shift_c = {rem[WIDTH-1:0], quo[WIDTH-1]};
    fits_c      = (rem_shift_c >= {1'b0, divisor});
    rem_sub_c   = rem_shift_c - {1'b0, divisor};
    case (op_q)
      2'b00:   fix_c = (sign1 ^ sign2) ? WIDTH'(-quo) : quo;
      2'b01:   fix_c = quo;
      2'b10:   fix_c = sign1 ? WIDTH'(-rem[WIDTH-1:0]) : rem[WIDTH-1:0];
      default: fix_c = rem[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (div_zero_c || overflow_c) ? DONE : CALC;
      CALC:    if (last_c) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      counter <= '0;
      op_q    <= '0;
      sign1   <= 1'b0;
      sign2   <= 1'b0;
      quo     <= '0;
      divisor <= '0;
      rem     <= '0;
    end else begin
      busy <= (state_next == CALC) || (state_next == FIX);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            sign1   <= neg1_c;
            sign2   <= neg2_c;
            quo     <= abs1_c;
            divisor <= abs2_c;
            rem     <= '0;
            counter <= '0;
            // Special cases bypass the iteration entirely
            if (div_zero_c)      result <= op[1] ? number1 : '1;
            else if (overflow_c) result <= op[1] ? '0 : MIN_NEG;
          end
        end
        CALC: begin
          rem     <= fits_c ? rem_sub_c : rem_shift_c;
          quo     <= {quo[WIDTH-2:0], fits_c};
          counter <= counter + CW'(1);
        end
        FIX:     result <= fix_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, compared on done.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] number1, number2;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [31:0] sb[$];

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .number1(number1), .number2(number2),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Every done pulse must retire exactly one queued expectation
  always @(negedge clk) begin
    if (done) begin
      pulses++;
      if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("result", result, sb.pop_front());
    end
  end

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
    int n;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; op = o; number1 = a; number2 = b;
    sb.push_back(exp);
    busy_cnt = 0;
    @(posedge clk); #1;
    n = 1;
    start = 1'b0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat_exp));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), (lat_exp == 1) ? 32'd0 : 32'(lat_exp - 1));
    @(posedge clk); #1;
    check({tag, "_done_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int p0;
    rst = 1'b1; start = 1'b0; op = 2'b00; number1 = '0; number2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    do_op("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    do_op("divu_5_0",   2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("rem_5_0",    2'b10, 32'd5, 32'd0, 32'd5, 1);
    do_op("div_m5_0",   2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    do_op("remu_big",   2'b11, 32'hFFFF_FFFF, 32'd10, 32'd5, 34);

    // Reset during iteration 10 discards the operation
    p0 = pulses;
    @(negedge clk);
    start = 1'b1; op = 2'b01; number1 = 32'd1000; number2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    check("midrst_no_pulse", 32'(pulses - p0), 32'd0);
    do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 34);

    // start held high with operands changed mid-calculation
    p0 = pulses;
    @(negedge clk);
    start = 1'b1; op = 2'b01; number1 = 32'd100; number2 = 32'd7;
    sb.push_back(32'd14);
    repeat (6) @(posedge clk);
    @(negedge clk);
    number1 = 32'd50; number2 = 32'd5;
    sb.push_back(32'd10);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_first_done", {31'd0, done}, 32'd1);
    n = 0;
    while (!busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("held_restart_gap", 32'(n), 32'd2);
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_second_latency", 32'(n), 32'd35);
    @(posedge clk); #1;
    check("held_done_width", {31'd0, done}, 32'd0);
    repeat (40) @(posedge clk);
    check("held_pulse_count", 32'(pulses - p0), 32'd2);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
